// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the IF-stage branch target predictor: counter encodings and defaults.
package branch_target_predictor_pkg;

    localparam int DEFAULT_ENTRY_BITS = 4;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_RESET = CNT_WNT;
    localparam cnt_e CNT_ALLOC = CNT_WT;

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// 2-bit saturating up/down counter next-state logic; purely combinational.
module bp_sat_counter
    import branch_target_predictor_pkg::*;
(
    input  cnt_e cnt,
    input  logic taken,
    output cnt_e cnt_next
);

    always_comb begin
        // NOTE: default first so every path assigns cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_next = cnt_e'(cnt + 2'd1);
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt_e'(cnt - 2'd1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle lookup for IF, training from resolved EX branches.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRY_BITS = DEFAULT_ENTRY_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_en,
    input  logic [31:0] PC_EX,
    input  logic        br_taken_EX,
    input  logic [31:0] br_target_EX,
    input  logic        predict_taken_EX,
    output logic [31:0] br_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = 30 - ENTRY_BITS;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    cnt_e             cnt_q    [ENTRIES];

    logic [ENTRY_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    cnt_e                  ex_cnt_next;

    assign if_idx = PC_IF[ENTRY_BITS+1:2];
    assign if_tag = PC_IF[31:ENTRY_BITS+2];
    assign ex_idx = PC_EX[ENTRY_BITS+1:2];
    assign ex_tag = PC_EX[31:ENTRY_BITS+2];

    // Word-aligned fetch: the byte-offset bits never influence index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

    // Lookup reads the stored arrays only, so a same-cycle update is seen next cycle.
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign predict_taken  = if_hit && cnt_q[if_idx][1];
    assign predict_target = if_hit ? target_q[if_idx] : 32'd0;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    bp_sat_counter u_sat_counter (
        .cnt      (cnt_q[ex_idx]),
        .taken    (br_taken_EX),
        .cnt_next (ex_cnt_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole table is cleared on reset because a stale valid bit would
            // produce a false taken prediction right after reset.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                cnt_q[i]    <= CNT_RESET;
            end
            br_count         <= 32'd0;
            mispredict_count <= 32'd0;
        end else if (update_en) begin
            br_count <= br_count + 32'd1;
            if (predict_taken_EX != br_taken_EX)
                mispredict_count <= mispredict_count + 32'd1;

            if (ex_hit) begin
                cnt_q[ex_idx] <= ex_cnt_next;
                if (br_taken_EX) target_q[ex_idx] <= br_target_EX;
            end else if (br_taken_EX) begin
                // Not-taken misses never allocate, so cold never-taken branches stay out.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= br_target_EX;
                cnt_q[ex_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC_IF = '0;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en = 1'b0;
    logic [31:0] PC_EX = '0;
    logic        br_taken_EX = 1'b0;
    logic [31:0] br_target_EX = '0;
    logic        predict_taken_EX = 1'b0;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    branch_target_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .PC_IF            (PC_IF),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .update_en        (update_en),
        .PC_EX            (PC_EX),
        .br_taken_EX      (br_taken_EX),
        .br_target_EX     (br_target_EX),
        .predict_taken_EX (predict_taken_EX),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] brc;
        logic [31:0] mpc;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_brc = 0;
    logic [31:0] model_mpc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".taken"},  {31'd0, predict_taken}, {31'd0, e.pt});
            check({e.name, ".target"}, predict_target,          e.tgt);
            check({e.name, ".brc"},    br_count,                e.brc);
            check({e.name, ".mpc"},    mispredict_count,        e.mpc);
        end
    end

    // One cycle: drive inputs after the edge; expected lookup reflects pre-update state.
    task automatic step(input string name, input logic r, input logic [31:0] pc_if,
                        input logic upd, input logic [31:0] pc_ex, input logic tk,
                        input logic [31:0] tgt, input logic pex,
                        input logic exp_pt, input logic [31:0] exp_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        PC_IF            = pc_if;
        update_en        = upd;
        PC_EX            = pc_ex;
        br_taken_EX      = tk;
        br_target_EX     = tgt;
        predict_taken_EX = pex;
        if (r) begin
            model_brc = 0;
            model_mpc = 0;
        end
        e.name = name; e.pt = exp_pt; e.tgt = exp_tgt; e.brc = model_brc; e.mpc = model_mpc;
        sb.push_back(e);
        if (!r && upd) begin
            model_brc = model_brc + 1;
            if (pex != tk) model_mpc = model_mpc + 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //    name          rst pc_if     upd pc_ex     tk tgt       pex exp_pt exp_tgt
        step("reset0",      1, 32'h100, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        // Cold taken: allocation visible only from the next cycle
        step("cold_upd",    0, 32'h100, 1, 32'h100, 1, 32'h40,  0,  0, 32'h0);
        step("cold_hit",    0, 32'h100, 0, 32'h0,   0, 32'h0,   0,  1, 32'h40);
        // Hysteresis walk WT -> WNT -> WT -> ST -> WT -> ST (saturate) -> WT
        step("hy_nt",       0, 32'h100, 1, 32'h100, 0, 32'h0,   1,  1, 32'h40);
        step("hy_wnt",      0, 32'h100, 1, 32'h100, 1, 32'h40,  0,  0, 32'h40);
        step("hy_wt",       0, 32'h100, 1, 32'h100, 1, 32'h40,  1,  1, 32'h40);
        step("hy_st",       0, 32'h100, 1, 32'h100, 0, 32'h0,   1,  1, 32'h40);
        step("hy_st_nt",    0, 32'h100, 1, 32'h100, 1, 32'h40,  1,  1, 32'h40);
        step("hy_sat1",     0, 32'h100, 1, 32'h100, 1, 32'h40,  1,  1, 32'h40);
        step("hy_sat2",     0, 32'h100, 1, 32'h100, 1, 32'h40,  1,  1, 32'h40);
        step("hy_sat3",     0, 32'h100, 1, 32'h100, 0, 32'h0,   1,  1, 32'h40);
        step("hy_hold",     0, 32'h100, 0, 32'h0,   0, 32'h0,   0,  1, 32'h40);
        // Alias: 0x140 shares index 0 with 0x100
        step("alias_miss",  0, 32'h140, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        step("alias_evict", 0, 32'h100, 1, 32'h140, 1, 32'h80,  0,  1, 32'h40);
        step("alias_old",   0, 32'h100, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        step("alias_new",   0, 32'h140, 0, 32'h0,   0, 32'h0,   0,  1, 32'h80);
        step("lowbits_if",  0, 32'h143, 1, 32'h140, 1, 32'h90,  1,  1, 32'h80);
        step("tgt_upd",     0, 32'h140, 1, 32'h141, 0, 32'h500, 1,  1, 32'h90);
        step("nt_keep_tgt", 0, 32'h140, 0, 32'h0,   0, 32'h0,   0,  1, 32'h90);
        // Same-cycle lookup/update, and no allocation on a not-taken miss
        step("same_cyc",    0, 32'h200, 1, 32'h200, 1, 32'h300, 0,  0, 32'h0);
        step("same_next",   0, 32'h200, 1, 32'h204, 0, 32'h500, 0,  1, 32'h300);
        step("nt_noalloc",  0, 32'h204, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        // Reset mid-run with an update pending: cleared immediately, update dropped
        step("rst_mid",     1, 32'h200, 1, 32'h200, 1, 32'h300, 0,  0, 32'h0);
        step("rst_hold",    1, 32'h200, 1, 32'h200, 1, 32'h300, 0,  0, 32'h0);
        step("rst_rel",     0, 32'h200, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        step("rst_after",   0, 32'h140, 0, 32'h0,   0, 32'h0,   0,  0, 32'h0);

        // Stats wrap from a preloaded all-ones br_count
        @(posedge clk);
        #1;
        force dut.br_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        model_brc = 32'hFFFF_FFFF;
        step("wrap_pre",    0, 32'h0,   1, 32'h300, 1, 32'h20,  1,  0, 32'h0);
        step("wrap_zero",   0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 32'h0);
        step("idle_hold",   0, 32'h300, 0, 32'h0,   0, 32'h0,   0,  1, 32'h20);

        repeat (3) @(posedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
